// File: rtl/ultrasound_scheduler_pkg.sv
// Shared definitions for the ultrasound scan scheduler and its consumers
// (main FSM, orientation and path math).
//   - us_state_e     : scheduler FSM states
//   - LOC_* params   : width and bit positions of the {theta, r} location word
//   - us_echo_t      : best-echo-so-far record
//   - pack_location  : builds the location word, zero when nothing was found
package ultrasound_pkg;

  localparam int LOC_R_W       = 8;
  localparam int LOC_THETA_W   = 4;
  localparam int LOC_W         = LOC_THETA_W + LOC_R_W;
  localparam int LOC_R_LSB     = 0;
  localparam int LOC_R_MSB     = LOC_R_LSB + LOC_R_W - 1;
  localparam int LOC_THETA_LSB = LOC_R_MSB + 1;
  localparam int LOC_THETA_MSB = LOC_THETA_LSB + LOC_THETA_W - 1;

  localparam int TIMER_W       = 32;
  localparam int MASK_W        = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETTLE,
    ST_TRIGGER,
    ST_WAIT,
    ST_GUARD,
    ST_DONE
  } us_state_e;

  typedef struct packed {
    logic                   found;
    logic [LOC_THETA_W-1:0] theta;
    logic [LOC_R_W-1:0]     r;
  } us_echo_t;

  function automatic logic [LOC_W-1:0] pack_location(input us_echo_t e);
    logic [LOC_W-1:0] loc;
    loc = '0;
    if (e.found) begin
      loc[LOC_THETA_MSB:LOC_THETA_LSB] = e.theta;
      loc[LOC_R_MSB:LOC_R_LSB]         = e.r;
    end
    return loc;
  endfunction

endpackage

// File: rtl/ultrasound_scheduler_if.sv
// Signal bundle between the scan scheduler, the main FSM and the ranging core.
//   slave  modport : the scheduler (answers run_ultrasound, drives the mux,
//                    trigger and the scan results)
//   master modport : the environment (main FSM + ranging core)
// Signals:
//   run_ultrasound  start request          ultrasound_done one-cycle completion
//   range_valid     echo pulse from core   range_value     echo range
//   sensor_select   transducer mux select  trigger         fire pulse to core
//   busy            scan in progress       rover_location  {theta, r}
//   target_found    any valid echo         timeout_mask    per-sensor timeouts
interface ultrasound_scheduler_if;
  import ultrasound_pkg::*;

  logic                   run_ultrasound;
  logic                   range_valid;
  logic [LOC_R_W-1:0]     range_value;
  logic [LOC_THETA_W-1:0] sensor_select;
  logic                   trigger;
  logic                   busy;
  logic                   ultrasound_done;
  logic [LOC_W-1:0]       rover_location;
  logic                   target_found;
  logic [MASK_W-1:0]      timeout_mask;

  modport slave (
    input  run_ultrasound, range_valid, range_value,
    output sensor_select, trigger, busy, ultrasound_done,
           rover_location, target_found, timeout_mask
  );

  modport master (
    output run_ultrasound, range_valid, range_value,
    input  sensor_select, trigger, busy, ultrasound_done,
           rover_location, target_found, timeout_mask
  );

endinterface

// File: rtl/ultrasound_scheduler_interval_timer.sv
// Load / count-down / expire interval timer, shared by the settle, echo
// timeout and crosstalk guard intervals.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   load_i        load load_val_i this cycle (takes effect next cycle)
//   load_val_i    interval length N; expire_o is high on the N-th cycle
//                 after the load, N=0 behaves as N=1
//   expire_o      interval elapsed (the last cycle of the interval)
module interval_timer
  import ultrasound_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  output logic               expire_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = (load_val_i == '0) ? TIMER_W'(1) : load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // The count reads N in the first cycle after the load, so it reaches 1
  // exactly on the N-th cycle.
  assign expire_o = (count_q == TIMER_W'(1));

endmodule

// File: rtl/ultrasound_scheduler.sv
// Round-robin scan of up to 16 ultrasound transducers through one shared
// ranging core. Each run selects every sensor in turn, waits for the mux to
// settle, fires the core, waits for an echo (or times out), then holds a
// quiet guard gap. The nearest in-range echo is reported as {theta, r}.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   bus (slave)   run/done handshake, ranging core signals, scan results
module ultrasound_scheduler
  import ultrasound_pkg::*;
#(
  parameter int unsigned        NUM_SENSORS    = 12,
  parameter int unsigned        SETTLE_CYCLES  = 27,
  parameter int unsigned        TIMEOUT_CYCLES = 1350000,
  parameter int unsigned        GUARD_CYCLES   = 270000,
  parameter logic [LOC_R_W-1:0] MIN_RANGE      = 8'd1,
  parameter logic [LOC_R_W-1:0] MAX_RANGE      = 8'd240
) (
  input  logic                   clock,
  input  logic                   reset,
  ultrasound_scheduler_if.slave  bus
);

  us_state_e              state_q, state_d;
  logic [LOC_THETA_W-1:0] idx_q, idx_d;
  us_echo_t               scratch_q, scratch_d;
  logic [MASK_W-1:0]      mask_q, mask_d;

  logic [LOC_THETA_W-1:0] sel_q, sel_d;
  logic                   trig_q, trig_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [LOC_W-1:0]       loc_q, loc_d;
  logic                   found_q, found_d;
  logic [MASK_W-1:0]      tmask_q, tmask_d;

  logic                   timer_load;
  logic [TIMER_W-1:0]     timer_val;
  logic                   timer_expire;

  logic                   echo_in_range;
  logic                   last_sensor;
  logic                   scan_end;

  interval_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .expire_o   (timer_expire)
  );

  assign echo_in_range = (bus.range_value >= MIN_RANGE) &&
                         (bus.range_value <= MAX_RANGE);
  assign last_sensor   = (32'(idx_q) >= NUM_SENSORS - 32'd1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    scratch_d  = scratch_q;
    mask_d     = mask_q;
    timer_load = 1'b0;
    timer_val  = '0;
    scan_end   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.run_ultrasound) begin
          scratch_d.found = 1'b0;
          scratch_d.theta = '0;
          scratch_d.r     = 8'hFF;
          mask_d          = '0;
          idx_d           = '0;
          state_d         = ST_SELECT;
        end
      end
      ST_SELECT: begin
        timer_load = 1'b1;
        timer_val  = TIMER_W'(SETTLE_CYCLES);
        state_d    = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (timer_expire) state_d = ST_TRIGGER;
      end
      ST_TRIGGER: begin
        timer_load = 1'b1;
        timer_val  = TIMER_W'(TIMEOUT_CYCLES);
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // An echo on the expiry cycle still counts as an echo, so
        // range_valid is tested before the timeout.
        if (bus.range_valid) begin
          // Strict less-than keeps the lowest index on equal ranges.
          if (echo_in_range &&
              (!scratch_q.found || (bus.range_value < scratch_q.r))) begin
            scratch_d.found = 1'b1;
            scratch_d.theta = idx_q;
            scratch_d.r     = bus.range_value;
          end
          timer_load = 1'b1;
          timer_val  = TIMER_W'(GUARD_CYCLES);
          state_d    = ST_GUARD;
        end else if (timer_expire) begin
          mask_d[idx_q] = 1'b1;
          timer_load    = 1'b1;
          timer_val     = TIMER_W'(GUARD_CYCLES);
          state_d       = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (timer_expire) begin
          if (last_sensor) begin
            scan_end = 1'b1;
            state_d  = ST_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_SELECT;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so each one is valid
  // in the same cycle as the state it belongs to.
  always_comb begin
    sel_d   = sel_q;
    loc_d   = loc_q;
    found_d = found_q;
    tmask_d = tmask_q;
    trig_d  = (state_d == ST_TRIGGER);
    busy_d  = (state_d != ST_IDLE);
    done_d  = scan_end;
    if (state_d == ST_SELECT) sel_d = idx_d;
    if (scan_end) begin
      loc_d   = pack_location(scratch_q);
      found_d = scratch_q.found;
      tmask_d = mask_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      sel_q   <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      loc_q   <= '0;
      found_q <= 1'b0;
      tmask_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      loc_q   <= loc_d;
      found_q <= found_d;
      tmask_q <= tmask_d;
    end
  end

  // Scan scratch is always initialised on an accepted start, so it carries
  // no reset.
  always_ff @(posedge clock) begin
    scratch_q <= scratch_d;
    mask_q    <= mask_d;
  end

  assign bus.sensor_select   = sel_q;
  assign bus.trigger         = trig_q;
  assign bus.busy            = busy_q;
  assign bus.ultrasound_done = done_q;
  assign bus.rover_location  = loc_q;
  assign bus.target_found    = found_q;
  assign bus.timeout_mask    = tmask_q;

endmodule
